// File: rtl/dmem_arbiter.sv
//----------------------------------------------------------------------------
// dmem_arbiter: two-port request/ack arbiter in front of a single-port data memory.
// Optional build macro: DMEM_ARB_FIXED_PRI_EN (fixed port-0 priority instead of round-robin)
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module dmem_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              gnt_id
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              op_we;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic              cand0;
    logic              cand1;
    logic              grant_valid;
    logic              grant_sel;
`ifndef DMEM_ARB_FIXED_PRI_EN
    logic              last_gnt;
`endif

    // In RESP the winner's req is still high, so it is masked out of the vote.
    always_comb begin
        cand0 = 1'b0;
        cand1 = 1'b0;
        if (state == ST_IDLE) begin
            cand0 = req0;
            cand1 = req1;
        end else if (state == ST_RESP) begin
            cand0 = req0 && gnt_id;
`ifdef DMEM_ARB_FIXED_PRI_EN
            cand1 = 1'b0;
`else
            cand1 = req1 && !gnt_id;
`endif
        end
        grant_valid = cand0 || cand1;
`ifdef DMEM_ARB_FIXED_PRI_EN
        grant_sel = !cand0;
`else
        grant_sel = (cand0 && cand1) ? !last_gnt : cand1;
`endif
    end

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:   state_nxt = grant_valid ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = grant_valid ? ST_ACCESS : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            gnt_id   <= 1'b0;
            op_we    <= 1'b0;
            op_addr  <= '0;
            op_wdata <= '0;
            rdata0   <= '0;
            rdata1   <= '0;
`ifndef DMEM_ARB_FIXED_PRI_EN
            last_gnt <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
            if (grant_valid) begin
                gnt_id   <= grant_sel;
                op_we    <= grant_sel ? we1    : we0;
                op_addr  <= grant_sel ? addr1  : addr0;
                op_wdata <= grant_sel ? wdata1 : wdata0;
            end
            if (state == ST_ACCESS && !op_we) begin
                if (gnt_id) rdata1 <= mem_rdata;
                else        rdata0 <= mem_rdata;
            end
`ifndef DMEM_ARB_FIXED_PRI_EN
            if (state == ST_RESP) last_gnt <= gnt_id;
`endif
        end
    end

    assign mem_we    = (state == ST_ACCESS) && op_we;
    assign mem_addr  = op_addr;
    assign mem_wdata = op_wdata;
    assign busy      = (state != ST_IDLE);
    assign ack0      = (state == ST_RESP) && !gnt_id;
    assign ack1      = (state == ST_RESP) &&  gnt_id;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
//----------------------------------------------------------------------------
// tb_dmem_arbiter: directed vector bench for dmem_arbiter with a behavioural memory.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_arbiter;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int NV     = 24;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
    logic              ack0, ack1, mem_we, busy, gnt_id;
    logic [DATA_W-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_init = 1'b1;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_vec = 0;
    int n_err = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .gnt_id(gnt_id)
    );

    always #5 CLK = ~CLK;

    // Word i initially holds 0x1000_0000 + i.
    assign mem_rdata = mem[mem_addr];
    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= 32'h1000_0000 + i;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    typedef struct {
        logic        rst_n;
        logic        q0, w0;
        logic [6:0]  a0;
        logic [31:0] d0;
        logic        q1, w1;
        logic [6:0]  a1;
        logic [31:0] d1;
        logic        k0, k1, b, g, m;
        logic [31:0] r0, r1;
    } vec_t;

    vec_t vt [NV];

    function automatic vec_t mk(input logic r, q0, w0, input logic [6:0] a0, input logic [31:0] d0,
                                input logic q1, w1, input logic [6:0] a1, input logic [31:0] d1,
                                input logic k0, k1, b, g, m, input logic [31:0] r0, r1);
        vec_t v;
        v.rst_n = r; v.q0 = q0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.q1 = q1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.k0 = k0; v.k1 = k1; v.b = b; v.g = g; v.m = m; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    int ack_port [8];
    int ack_cyc  [8];
    int n_ack;

    initial begin
        // rst q0 w0 a0  d0            q1 w1 a1   d1            k0 k1 b g m  rd0           rd1
        vt[0]  = mk(1, 1,1, 10, 32'h12345678, 0,0, 0, 0,            0,0,1,0,1, 0,            0);
        vt[1]  = mk(1, 1,1, 10, 32'h12345678, 0,0, 0, 0,            1,0,1,0,0, 0,            0);
        vt[2]  = mk(1, 1,1, 10, 32'h12345678, 0,0, 0, 0,            0,0,0,0,0, 0,            0);
        vt[3]  = mk(1, 1,0, 10, 0,            0,0, 0, 0,            0,0,1,0,0, 0,            0);
        vt[4]  = mk(1, 1,0, 10, 0,            0,0, 0, 0,            1,0,1,0,0, 32'h12345678, 0);
        vt[5]  = mk(1, 1,0, 10, 0,            0,0, 0, 0,            0,0,0,0,0, 32'h12345678, 0);
        vt[6]  = mk(0, 0,0, 0,  0,            0,0, 0, 0,            0,0,0,0,0, 0,            0);
        vt[7]  = mk(1, 1,0, 1,  0,            1,1, 2, 32'hA5A5A5A5, 0,0,1,0,0, 0,            0);
        vt[8]  = mk(1, 1,0, 1,  0,            1,1, 2, 32'hA5A5A5A5, 1,0,1,0,0, 32'h10000001, 0);
        vt[9]  = mk(1, 1,0, 1,  0,            1,1, 2, 32'hA5A5A5A5, 0,0,1,1,1, 32'h10000001, 0);
        vt[10] = mk(1, 0,0, 0,  0,            1,1, 2, 32'hA5A5A5A5, 0,1,1,1,0, 32'h10000001, 0);
        vt[11] = mk(1, 0,0, 0,  0,            1,1, 2, 32'hA5A5A5A5, 0,0,0,1,0, 32'h10000001, 0);
        vt[12] = mk(1, 1,0, 5,  0,            0,0, 0, 0,            0,0,1,0,0, 32'h10000001, 0);
        vt[13] = mk(1, 1,0, 5,  0,            0,0, 0, 0,            1,0,1,0,0, 32'h10000005, 0);
        vt[14] = mk(1, 1,0, 5,  0,            0,0, 0, 0,            0,0,0,0,0, 32'h10000005, 0);
        vt[15] = mk(1, 0,0, 0,  0,            1,1,127,32'hFFFFFFFF, 0,0,1,1,1, 32'h10000005, 0);
        vt[16] = mk(1, 1,0,127, 0,            1,1,127,32'hFFFFFFFF, 0,1,1,1,0, 32'h10000005, 0);
        vt[17] = mk(1, 1,0,127, 0,            1,1,127,32'hFFFFFFFF, 0,0,1,0,0, 32'h10000005, 0);
        vt[18] = mk(1, 1,0,127, 0,            0,0, 0, 0,            1,0,1,0,0, 32'hFFFFFFFF, 0);
        vt[19] = mk(1, 1,0,127, 0,            0,0, 0, 0,            0,0,0,0,0, 32'hFFFFFFFF, 0);
        vt[20] = mk(1, 0,0, 0,  0,            0,0, 0, 0,            0,0,0,0,0, 32'hFFFFFFFF, 0);
        vt[21] = mk(1, 0,0, 0,  0,            1,0, 2, 0,            0,0,1,1,0, 32'hFFFFFFFF, 0);
        vt[22] = mk(1, 0,0, 0,  0,            1,0, 2, 0,            0,1,1,1,0, 32'hFFFFFFFF, 32'hA5A5A5A5);
        vt[23] = mk(1, 0,0, 0,  0,            1,0, 2, 0,            0,0,0,1,0, 32'hFFFFFFFF, 32'hA5A5A5A5);

        // Reset values, then a reset landing in the middle of a write ACCESS.
        repeat (2) @(posedge CLK);
        #1;
        mem_init = 1'b0;
        chk("rst.ack0", {31'b0, ack0}, 0);
        chk("rst.ack1", {31'b0, ack1}, 0);
        chk("rst.busy", {31'b0, busy}, 0);
        chk("rst.mem_we", {31'b0, mem_we}, 0);
        chk("rst.gnt_id", {31'b0, gnt_id}, 0);
        chk("rst.mem_addr", {25'b0, mem_addr}, 0);
        chk("rst.mem_wdata", mem_wdata, 0);
        chk("rst.rdata0", rdata0, 0);
        chk("rst.rdata1", rdata1, 0);
        RST_N = 1'b1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 7'd5; wdata0 = 32'hDEADBEEF;
        @(posedge CLK); #1;
        chk("midrst.pre_mem_we", {31'b0, mem_we}, 1);
        chk("midrst.pre_mem_addr", {25'b0, mem_addr}, 5);
        #2;
        RST_N = 1'b0;
        #1;
        chk("midrst.mem_we", {31'b0, mem_we}, 0);
        chk("midrst.busy", {31'b0, busy}, 0);
        chk("midrst.mem_addr", {25'b0, mem_addr}, 0);
        chk("midrst.mem_wdata", mem_wdata, 0);
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        @(posedge CLK); #1;
        chk("midrst.ack0", {31'b0, ack0}, 0);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < NV; i++) begin
            RST_N = vt[i].rst_n;
            req0 = vt[i].q0; we0 = vt[i].w0; addr0 = vt[i].a0; wdata0 = vt[i].d0;
            req1 = vt[i].q1; we1 = vt[i].w1; addr1 = vt[i].a1; wdata1 = vt[i].d1;
            @(posedge CLK); #1;
            chk($sformatf("v%0d.ack0", i), {31'b0, ack0}, {31'b0, vt[i].k0});
            chk($sformatf("v%0d.ack1", i), {31'b0, ack1}, {31'b0, vt[i].k1});
            chk($sformatf("v%0d.busy", i), {31'b0, busy}, {31'b0, vt[i].b});
            chk($sformatf("v%0d.gnt_id", i), {31'b0, gnt_id}, {31'b0, vt[i].g});
            chk($sformatf("v%0d.mem_we", i), {31'b0, mem_we}, {31'b0, vt[i].m});
            chk($sformatf("v%0d.rdata0", i), rdata0, vt[i].r0);
            chk($sformatf("v%0d.rdata1", i), rdata1, vt[i].r1);
        end

        // Both ports hold req continuously; record the first 8 completions.
        RST_N = 1'b0; req0 = 1'b0; req1 = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 7'd3;
        req1 = 1'b1; we1 = 1'b0; addr1 = 7'd4;
        n_ack = 0;
        for (int c = 0; c < 40 && n_ack < 8; c++) begin
            @(posedge CLK); #1;
            if (ack0 && ack1) chk("cont.ack_exclusive", 32'd1, 32'd0);
            if (ack0 || ack1) begin
                ack_port[n_ack] = ack1 ? 1 : 0;
                ack_cyc[n_ack]  = c;
                if (ack0) chk($sformatf("cont.rdata0_%0d", n_ack), rdata0, 32'h10000003);
                else      chk($sformatf("cont.rdata1_%0d", n_ack), rdata1, 32'h10000004);
                n_ack++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("cont.ack_count", n_ack, 8);
        for (int k = 0; k < n_ack; k++) begin
`ifdef DMEM_ARB_FIXED_PRI_EN
            chk($sformatf("cont.port_%0d", k), ack_port[k], 0);
            if (k > 0) chk($sformatf("cont.gap_%0d", k), ack_cyc[k] - ack_cyc[k-1], 3);
`else
            chk($sformatf("cont.port_%0d", k), ack_port[k], k % 2);
            if (k > 0) chk($sformatf("cont.gap_%0d", k), ack_cyc[k] - ack_cyc[k-1], 2);
`endif
        end
        repeat (3) @(posedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
